hydra_main_control: RTL

Multi-cycle main control FSM for the Hydra 16-bit core, sitting directly upstream of the ALU control unit. It accepts a 4-bit opcode from the fetch stage over a valid/ready handshake, then sequences the instruction through DECODE, EXEC, MEM and WB. It drives the 2-bit `alu_op` consumed by the ALU control unit, plus all datapath enables. Memory accesses are guarded by a bounded wait with an error pulse.

---
 rtl/hydra_pkg.sv | 34 +++
 rtl/hydra_opcode_decoder.sv | 26 ++
 rtl/hydra_main_control.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/hydra_pkg.sv
// Shared types and constants for the Hydra main control FSM:
// state encoding, opcode map and alu_op encodings.
package hydra_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    // Opcodes 0000-0111 are R-type; 1101-1111 are illegal.
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1010;
    localparam logic [3:0] OP_BNE = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef struct packed {
        logic is_rtype;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic is_bne;
        logic is_jmp;
        logic is_illegal;
    } op_class_t;

endpackage

// File: rtl/hydra_opcode_decoder.sv
// Combinational map from the latched opcode to one-hot instruction class flags.
module hydra_opcode_decoder
    import hydra_pkg::*;
(
    input  logic [3:0] opcode_q,
    output op_class_t  op_class
);

    // Classify the opcode; the MSB clear marks every R-type encoding.
    always_comb begin
        op_class = '0;
        if (opcode_q[3] == 1'b0) begin
            op_class.is_rtype = 1'b1;
        end else begin
            case (opcode_q)
                OP_LW:   op_class.is_lw      = 1'b1;
                OP_SW:   op_class.is_sw      = 1'b1;
                OP_BEQ:  op_class.is_beq     = 1'b1;
                OP_BNE:  op_class.is_bne     = 1'b1;
                OP_JMP:  op_class.is_jmp     = 1'b1;
                default: op_class.is_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/hydra_main_control.sv
// Multi-cycle main control FSM for the Hydra 16-bit core: FETCH/DECODE/EXEC/MEM/WB
// sequencing with a bounded memory wait and single-cycle error pulses.
module hydra_main_control
    import hydra_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [3:0] opcode,
    output logic       instr_ready,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       pc_write,
    output logic       jump,
    output logic       illegal,
    output logic       mem_err
);

    localparam logic [7:0] WAIT_LAST_C = 8'(MEM_WAIT_MAX - 1);

    state_e     state_r;
    state_e     state_nxt_s;
    logic [3:0] opcode_r;
    logic [3:0] opcode_nxt_s;
    logic [7:0] wait_cnt_r;
    logic [7:0] wait_cnt_nxt_s;
    logic       instr_ready_s;
    op_class_t  op_class_s;

    hydra_opcode_decoder u_decoder (
        .opcode_q (opcode_r),
        .op_class (op_class_s)
    );

    // State, latched opcode and MEM wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_FETCH;
            opcode_r   <= 4'b0000;
            wait_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_nxt_s;
            opcode_r   <= opcode_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // Next-state and output decode from the state and latched opcode class.
    always_comb begin
        state_nxt_s    = state_r;
        opcode_nxt_s   = opcode_r;
        wait_cnt_nxt_s = wait_cnt_r;
        instr_ready_s  = 1'b0;
        alu_op         = ALUOP_ADD;
        alu_src        = 1'b0;
        reg_dst        = 1'b0;
        mem_to_reg     = 1'b0;
        reg_write      = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        pc_write       = 1'b0;
        jump           = 1'b0;
        illegal        = 1'b0;
        mem_err        = 1'b0;
        case (state_r)
            ST_FETCH: begin
                instr_ready_s = 1'b1;
                if (instr_valid) begin
                    opcode_nxt_s = opcode;
                    state_nxt_s  = ST_DECODE;
                end else begin
                    state_nxt_s  = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (op_class_s.is_illegal) begin
                    illegal     = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_class_s.is_rtype) begin
                    alu_op      = ALUOP_RTYPE;
                    reg_dst     = 1'b1;
                    state_nxt_s = ST_WB;
                end else if (op_class_s.is_lw || op_class_s.is_sw) begin
                    alu_op         = ALUOP_ADD;
                    alu_src        = 1'b1;
                    wait_cnt_nxt_s = 8'd0;
                    state_nxt_s    = ST_MEM;
                end else if (op_class_s.is_beq || op_class_s.is_bne) begin
                    // zero feeds pc_write combinationally in this same cycle
                    alu_op      = ALUOP_SUB;
                    pc_write    = op_class_s.is_beq ? zero : ~zero;
                    state_nxt_s = ST_FETCH;
                end else if (op_class_s.is_jmp) begin
                    jump        = 1'b1;
                    pc_write    = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_MEM: begin
                alu_op    = ALUOP_ADD;
                alu_src   = 1'b1;
                mem_read  = op_class_s.is_lw;
                mem_write = op_class_s.is_sw;
                // A ready arriving on the last allowed cycle still completes normally.
                if (mem_ready) begin
                    state_nxt_s = op_class_s.is_lw ? ST_WB : ST_FETCH;
                end else if (wait_cnt_r == WAIT_LAST_C) begin
                    mem_err     = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + 8'd1;
                end
            end
            ST_WB: begin
                reg_write   = 1'b1;
                mem_to_reg  = op_class_s.is_lw;
                reg_dst     = op_class_s.is_rtype;
                state_nxt_s = ST_FETCH;
            end
            default: begin
                state_nxt_s = ST_FETCH;
            end
        endcase
    end

    // instr_ready is held low for the whole time reset is asserted.
    assign instr_ready = instr_ready_s & rst_n;

endmodule
